// File: rtl/seq_add32.sv
// seq_add32: multi-cycle ripple-carry adder.
//
// Computes a + b + c_in one CHUNK-bit slice per clock, least significant
// slice first, keeping the inter-slice carry in a register. A start/done
// handshake frames each operation: start is accepted in IDLE or in the
// single DONE cycle, busy is high while slices are being computed and done
// pulses for one cycle when sum/c_out/ovf have been updated.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous, active-high reset
//   start  - operation request, accepted when not busy
//   a, b   - WIDTH-bit operands, captured on an accepted start
//   c_in   - carry-in, captured on an accepted start
//   busy   - high while slices are being computed
//   done   - one-cycle pulse, result valid
//   sum    - WIDTH-bit result, holds the last completed value
//   c_out  - carry out of bit WIDTH-1
//   ovf    - signed overflow (carry into MSB xor carry out of MSB)

module seq_add32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NS    = WIDTH / CHUNK;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic [CHUNK-1:0] low_sum;
    logic             accept;
    logic             last_slice;

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_slice = (idx == LAST_IDX);

    // One slice of the ripple chain. low_sum adds everything below the
    // slice's top bit, so its MSB is the carry into that top bit; on the
    // last slice this is the carry into bit WIDTH-1 needed for ovf.
    always_comb begin
        a_slice   = a_reg[int'(idx) * CHUNK +: CHUNK];
        b_slice   = b_reg[int'(idx) * CHUNK +: CHUNK];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
        low_sum   = {1'b0, a_slice[CHUNK-2:0]} + {1'b0, b_slice[CHUNK-2:0]}
                    + {{(CHUNK-1){1'b0}}, carry};
        acc_next  = acc;
        acc_next[int'(idx) * CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE may accept a new start directly so that
    // back-to-back operations take exactly NS+1 cycles each.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. The published result is taken from acc_next on the last
    // slice edge, because the top slice is being written into acc on that
    // same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= slice_sum[CHUNK];
            if (last_slice) begin
                sum   <= acc_next;
                c_out <= slice_sum[CHUNK];
                ovf   <= low_sum[CHUNK-1] ^ slice_sum[CHUNK];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
